// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and
// the default operand width.
package seq_divider_pkg;

    // Divider control states: waiting for operands, iterating, holding a result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default operand/result width in bits (must be even and at least 4)
    localparam int DEFAULT_WIDTH = 32;

    // Number of bits needed for an iteration counter that can reach width
    function automatic int iter_cnt_bits(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_divider_sub_nb.sv
// Combinational N-bit subtractor with borrow-out, used for the trial
// subtraction in each restoring-division step.
module sub_nb #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    // Extend by one bit so the carry-out of the subtraction becomes the borrow
    assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH cycles
// per division, valid/ready handshakes on both operand and result sides.
// Build option: define SEQ_DIVIDER_SIGNED_EN to add the signed_op input and
// two's-complement division (truncating toward zero) on the same datapath.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = iter_cnt_bits(WIDTH);

    state_t           state;
    logic [CW-1:0]    iter_cnt;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] quo_work;
    logic [WIDTH-1:0] dsr;
    logic             neg_quo;
    logic             neg_rem;

    logic [WIDTH-1:0] acc_dividend;
    logic [WIDTH-1:0] acc_divisor;
    logic             acc_neg_quo;
    logic             acc_neg_rem;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial_diff;
    logic             trial_borrow;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] next_quo;
    logic             last_iter;
    logic             diff_msb_unused;

    // Two's-complement negation at the operand width
    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // Operand conditioning at acceptance: the datapath always divides
    // magnitudes; the signs needed to fix up the result are captured here.
    always_comb begin
        acc_dividend = dividend;
        acc_divisor  = divisor;
        acc_neg_quo  = 1'b0;
        acc_neg_rem  = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        if (signed_op) begin
            acc_neg_quo = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            acc_neg_rem = dividend[WIDTH-1];
            if (dividend[WIDTH-1]) begin
                acc_dividend = twos_neg(dividend);
            end
            if (divisor[WIDTH-1]) begin
                acc_divisor = twos_neg(divisor);
            end
        end
`endif
    end

    // Shift the next dividend bit into the partial remainder for the trial subtract
    always_comb begin
        shifted = {part_rem, quo_work[WIDTH-1]};
    end

    sub_nb #(
        .N(WIDTH + 1)
    ) u_sub (
        .a      (shifted),
        .b      ({1'b0, dsr}),
        .diff   (trial_diff),
        .borrow (trial_borrow)
    );

    // A kept difference is always below the divisor, so its top bit is zero
    assign diff_msb_unused = trial_diff[WIDTH];

    // Restoring step: keep the difference on no borrow, otherwise restore;
    // the quotient bit shifted in is the inverted borrow.
    always_comb begin
        next_rem  = trial_borrow ? shifted[WIDTH-1:0] : trial_diff[WIDTH-1:0];
        next_quo  = {quo_work[WIDTH-2:0], ~trial_borrow};
        last_iter = (iter_cnt == CW'(WIDTH - 1));
    end

    // Control FSM and all datapath/result registers, reset synchronously
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            iter_cnt    <= '0;
            part_rem    <= '0;
            quo_work    <= '0;
            dsr         <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        iter_cnt <= '0;
                        part_rem <= '0;
                        quo_work <= acc_dividend;
                        dsr      <= acc_divisor;
                        neg_quo  <= acc_neg_quo;
                        neg_rem  <= acc_neg_rem;
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    part_rem <= next_rem;
                    quo_work <= next_quo;
                    iter_cnt <= iter_cnt + CW'(1);
                    if (last_iter) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        div_by_zero <= 1'b0;
                        quotient    <= neg_quo ? twos_neg(next_quo) : next_quo;
                        remainder   <= neg_rem ? twos_neg(next_rem) : next_rem;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random
// operations compared against an arithmetic reference model.
// Define SEQ_DIVIDER_SIGNED_EN to also exercise signed division.
module tb_seq_divider;
    import seq_divider_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic         signed_op;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    seq_divider #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
        .signed_op   (signed_op),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, actual, expected);
        end
    endtask

    // Reference behaviour from plain arithmetic on the operands
    task automatic refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                            output logic [W-1:0] q, output logic [W-1:0] r,
                            output logic dz);
        logic [W-1:0] mostNeg;
        mostNeg = '0;
        mostNeg[W-1] = 1'b1;
        dz = 1'b0;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (sgn) begin
            if (a == mostNeg && b == '1) begin
                q = mostNeg;
                r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Run one division: present operands, time the result, check it,
    // optionally stall the consumer, then hand the result off.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sgn, input int stall, input string tag);
        logic [W-1:0] expQ;
        logic [W-1:0] expR;
        logic         expDz;
        int           waitCnt;
        int           lat;

        refModel(a, b, sgn, expQ, expR, expDz);

        waitCnt = 0;
        @(negedge clk);
        while (!in_ready && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) begin
            checkOutput({tag, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
            return;
        end

        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
`ifdef SEQ_DIVIDER_SIGNED_EN
        signed_op = sgn;
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
`ifdef SEQ_DIVIDER_SIGNED_EN
        signed_op = $urandom_range(0, 1);
`endif

        // Edges after the acceptance edge until out_valid; a zero divisor
        // gives a result in the cycle right after the acceptance cycle.
        lat = 0;
        while (!out_valid && lat < W + 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_latency"}, 32'(lat), (b == '0) ? 32'd0 : 32'(W));
        checkOutput({tag, "_quotient"}, quotient, expQ);
        checkOutput({tag, "_remainder"}, remainder, expR);
        checkOutput({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(expDz));

        // Consumer stall; new operand requests must be ignored meanwhile
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            dividend = $urandom;
            divisor  = $urandom;
            @(posedge clk);
            #1;
            checkOutput({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
            checkOutput({tag, "_stall_quotient"}, quotient, expQ);
            checkOutput({tag, "_stall_remainder"}, remainder, expR);
            checkOutput({tag, "_stall_dz"}, 32'(div_by_zero), 32'(expDz));
        end
        in_valid = 1'b0;

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_handoff_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_handoff_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Global time limit so the bench can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence
    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sgn;
        int           sel;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        signed_op = 1'b0;
`endif

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_dz", 32'(div_by_zero), 32'd0);
        checkOutput("reset_quotient", quotient, '0);
        checkOutput("reset_remainder", remainder, '0);
        rst_n = 1'b1;

        // Directed cases
        applyStimulus(32'd100, 32'd7, 1'b0, 0, "div_100_7");
        applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 0, "div_max_1");
        applyStimulus(32'd5, 32'd9, 1'b0, 0, "div_5_9");
        applyStimulus(32'h1234, 32'd0, 1'b0, 0, "div_by_zero");
        applyStimulus(32'd1000, 32'd33, 1'b0, 10, "stall_10");

        // Reset during iteration 12; in_valid is also high on the reset
        // edge and must lose to the reset.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        checkOutput("midreset_busy_valid", 32'(out_valid), 32'd0);
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        applyStimulus(32'd9, 32'd3, 1'b0, 0, "after_reset_9_3");

`ifdef SEQ_DIVIDER_SIGNED_EN
        applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "signed_m7_2");
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "signed_minneg_m1");
        applyStimulus(32'hFFFF_FFF9, 32'd0, 1'b1, 0, "signed_by_zero");
`endif

        // Randomized operations with a mix of divisor magnitudes
        for (int n = 0; n < 40; n++) begin
            a   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) begin
                b = '0;
            end else if (sel < 3) begin
                b = 32'($urandom_range(1, 15));
            end else if (sel < 5) begin
                b = $urandom >> $urandom_range(0, 31);
            end else begin
                b = $urandom;
            end
            sgn = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            sgn = 1'($urandom_range(0, 1));
`endif
            applyStimulus(a, b, sgn, $urandom_range(0, 3), $sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
